ex_muldiv_unit: RTL

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/rv32i_pkg.sv | 14 +
 rtl/ex_muldiv_unit.sv | 117 +++++++++++
 2 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I/M encodings and muldiv FSM state type
package rv32i_pkg;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} md_state_t;
endpackage

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage
module ex_muldiv_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [6:0]      opcode_in,
  input  logic [6:0]      funct7_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] data1_in,
  input  logic [XLEN-1:0] data2_in,
  input  logic [4:0]      rd_in,
  input  logic            flush_in,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wr_reg_n_out
);
  md_state_t         r_state, w_nstate;
  logic [5:0]        r_count;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic              r_neg, r_rneg;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;
  logic              w_mop, w_accept, w_sa, w_sb, w_an, w_bn, w_dz, w_ov, w_ge;
  logic [XLEN-1:0]   w_amag, w_bmag, w_spec, w_sub, w_q, w_r, w_fix;
  logic [XLEN:0]     w_sum, w_top;
  logic [2*XLEN-1:0] w_acc_n, w_prod;

  assign w_mop  = valid_in && opcode_in == OPC_OP && funct7_in == F7_MULDIV;
  assign w_sa   = funct3_in inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  assign w_sb   = funct3_in inside {F3_MULH, F3_DIV, F3_REM};
  assign w_an   = w_sa && data1_in[XLEN-1];
  assign w_bn   = w_sb && data2_in[XLEN-1];
  assign w_amag = w_an ? -data1_in : data1_in;
  assign w_bmag = w_bn ? -data2_in : data2_in;
  assign w_dz   = funct3_in[2] && data2_in == '0;
  assign w_ov   = funct3_in[2] && !funct3_in[0] && data1_in == {1'b1, {(XLEN-1){1'b0}}} && &data2_in;
  assign w_spec = w_dz ? (funct3_in[1] ? data1_in : '1) : (funct3_in[1] ? '0 : data1_in);
  // One radix-2 step: shift-add for multiply, restoring subtract for divide
  assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_top   = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge    = w_top >= {1'b0, r_b};
  assign w_sub   = w_top[XLEN-1:0] - r_b;
  assign w_acc_n = !r_f3[2] ? {w_sum, r_acc[XLEN-1:1]} :
                   w_ge ? {w_sub, r_acc[XLEN-2:0], 1'b1} : {w_top[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
  // Sign fix-up applied to the final step's value as it is written to result
  assign w_prod = r_neg ? -w_acc_n : w_acc_n;
  assign w_q    = r_neg ? -w_acc_n[XLEN-1:0] : w_acc_n[XLEN-1:0];
  assign w_r    = r_rneg ? -w_acc_n[2*XLEN-1:XLEN] : w_acc_n[2*XLEN-1:XLEN];
  assign w_fix  = !r_f3[2] ? (r_f3 == F3_MUL ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]) : (r_f3[1] ? w_r : w_q);
  assign result = r_result;
  assign rd_out = r_rd_out;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_nstate;
  end

  // Next state and handshake outputs; flush beats acceptance
  always_comb begin
    w_nstate     = r_state;
    w_accept     = 1'b0;
    stall_req    = (r_state == S_IDLE && w_mop) || r_state == S_CALC;
    done         = r_state == S_DONE;
    wr_reg_n_out = r_state != S_DONE;
    if (flush_in) w_nstate = S_IDLE;
    else if (r_state == S_IDLE && w_mop) begin
      w_accept = 1'b1;
      w_nstate = (w_dz || w_ov) ? S_DONE : S_CALC;
    end
    else if (r_state == S_CALC && r_count == 6'd31) w_nstate = S_DONE;
    else if (r_state == S_DONE) w_nstate = S_IDLE;
  end

  // Operand latch, iteration datapath and result/rd holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_f3     <= '0;
      r_rd     <= '0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else if (w_accept) begin
      r_acc   <= {{XLEN{1'b0}}, w_amag};
      r_b     <= w_bmag;
      r_f3    <= funct3_in;
      r_rd    <= rd_in;
      r_neg   <= w_an ^ w_bn;
      r_rneg  <= w_an;
      r_count <= '0;
      if (w_dz || w_ov) begin
        r_result <= w_spec;
        r_rd_out <= rd_in;
      end
    end else if (r_state == S_CALC && !flush_in) begin
      r_acc   <= w_acc_n;
      r_count <= r_count + 6'd1;
      if (r_count == 6'd31) begin
        r_result <= w_fix;
        r_rd_out <= r_rd;
      end
    end
  end
endmodule
